// File: rtl/std_pkg.sv
// std_pkg: shared clock and technology descriptor types
package std_pkg;
  typedef struct packed {
    logic [31:0] period_ps;
    logic        inverted;
  } std_clock_info_t;
  typedef enum logic [1:0] {
    STD_TECHNOLOGY_GENERIC,
    STD_TECHNOLOGY_ASIC_TSMC,
    STD_TECHNOLOGY_FPGA
  } std_technology_t;
endpackage

// File: rtl/asic_latch_ram.sv
// asic_latch_ram: latch-array storage with a registered write port and combinational read ports
module asic_latch_ram
  import std_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO = 'b0,
  parameter std_technology_t TECHNOLOGY = STD_TECHNOLOGY_ASIC_TSMC,
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  write_enable,
  input  logic [ADDR_WIDTH-1:0]                 write_addr,
  input  logic [DATA_WIDTH-1:0]                 write_data_in,
  output logic [DATA_WIDTH-1:0]                 write_data_out,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] read_addr,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] read_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] wa_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // capture the write request so the latches see stable address and data for a whole phase
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= write_enable;
      wa_q <= write_addr;
      wd_q <= write_data_in;
    end
  assign write_data_out = wd_q;
  if (TECHNOLOGY == STD_TECHNOLOGY_ASIC_TSMC) begin : g_latch
    logic phase;
    assign phase = clk ^ CLOCK_INFO.inverted;
    // the addressed row is transparent during the phase after the capture edge
    always_latch
      for (int i = 0; i < DEPTH; i++)
        if (phase && we_q && wa_q == ADDR_WIDTH'(i)) mem[i] <= wd_q;
  end else begin : g_flop
    // non-ASIC targets store directly at the push edge, keeping the same visible latency
    always_ff @(posedge clk)
      if (write_enable) mem[write_addr] <= write_data_in;
  end
  for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
    assign read_data[r] = mem[read_addr[r]];
  end
endmodule

// File: rtl/asic_latch_fifo.sv
// asic_latch_fifo: valid/ready FIFO built on a single latch RAM with flop-based pointers
module asic_latch_fifo
  import std_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO = 'b0,
  parameter std_technology_t TECHNOLOGY = STD_TECHNOLOGY_ASIC_TSMC,
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  assign in_ready  = count != FULL && !clear && !rst;
  assign out_valid = count != '0 && !clear;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // pointers wrap naturally at DEPTH; clear flushes ahead of any handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
    end
  asic_latch_ram #(
    .CLOCK_INFO(CLOCK_INFO),
    .TECHNOLOGY(TECHNOLOGY),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .READ_PORTS(1)
  ) u_ram (
    .clk           (clk),
    .rst           (rst),
    .write_enable  (push),
    .write_addr    (wr_ptr),
    .write_data_in (in_data),
    .write_data_out(),
    .read_addr     (rd_ptr),
    .read_data     (out_data)
  );
endmodule

// File: doc/asic_latch_fifo.md
ASIC_LATCH_FIFO -- requirements
Module: asic_latch_fifo

Interface
REQ-001 The block SHALL have the following parameters:
  - CLOCK_INFO: default 'b0; std_clock_info_t clock descriptor.
  - TECHNOLOGY: default STD_TECHNOLOGY_ASIC_TSMC; std_technology_t target.
  - DATA_WIDTH: default 1; entry width in bits.
  - ADDR_WIDTH: default 5; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 The block SHALL have the following ports; one clock, reset is asynchronous and active-high:
  - clk  in  1  sole clock.
  - rst  in  1  asynchronous active-high reset.
  - clear  in  1  synchronous flush.
  - in_valid  in  1  producer has data.
  - in_ready  out  1  FIFO accepts data.
  - in_data  in  DATA_WIDTH  write payload.
  - out_valid  out  1  head entry available.
  - out_ready  in  1  consumer takes head.
  - out_data  out  DATA_WIDTH  head payload.
  - count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-003 Push SHALL occur at a rising edge where in_valid && in_ready; pop SHALL occur at a rising edge where out_valid && out_ready.
REQ-004 in_ready SHALL equal (count != DEPTH) && !clear && !rst.
  - No push-on-full bypass: when full, a simultaneous pop does not enable in_ready.
REQ-005 out_valid SHALL equal (count != 0) && !clear.
REQ-006 On push, the latch RAM write port SHALL be driven with write_enable=1, write_addr=wr_ptr and write_data_in=in_data in the same cycle.
  - wr_ptr SHALL increment by 1 modulo DEPTH at that edge.
REQ-007 The read address SHALL be rd_ptr; out_data SHALL equal the RAM read data at rd_ptr.
  - On pop, rd_ptr SHALL increment by 1 modulo DEPTH.
REQ-008 Latency: data pushed at edge k SHALL be presented with out_valid=1 in the cycle following edge k, including when the FIFO was empty (first-word latency 1 cycle).
REQ-009 count update at each edge:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, or on neither.
REQ-010 Pointers SHALL wrap from DEPTH-1 to 0 with no other side effect; ordering SHALL be strictly first-in first-out.
REQ-011 clear high at an edge SHALL set wr_ptr, rd_ptr and count to 0.
  - clear has priority over push and pop.
  - No handshake can complete in that cycle (REQ-004, REQ-005).
REQ-012 out_data SHALL be don't-care when out_valid=0.
  - Stored entries are not reset; only control state is reset.
REQ-013 Simultaneous push and pop at count==1 SHALL read the old head and write a different slot.
  - The write address never equals the read address while count is between 1 and DEPTH-1.

Reset
REQ-014 While rst is high, independent of clk:
  - wr_ptr, rd_ptr and count SHALL be 0.
  - in_ready=0, out_valid=0, count=0.
REQ-015 Reset assertion mid-operation SHALL discard all contents.
  - The first cycle after release SHALL show in_ready=1, out_valid=0.
REQ-016 A write in flight at reset assertion SHALL NOT become visible after reset release.

Structure
REQ-017 No new package content SHALL be added; parameter types come from std_pkg, and DEPTH is a local constant.
REQ-018 Storage SHALL be exactly one asic_latch_ram instance with READ_PORTS=1 and matching CLOCK_INFO, TECHNOLOGY, DATA_WIDTH and ADDR_WIDTH.
  - Its write_data_out SHALL be left unused.
REQ-019 Pointers and count SHALL be plain flip-flops with asynchronous reset; no latches outside the RAM instance.

Verification
REQ-020 Fill, then drain.
  - Stimulus: ADDR_WIDTH=2, DATA_WIDTH=8; push 0x11,0x22,0x33,0x44 back-to-back with out_ready=0.
  - Required: count=4, in_ready=0. Raise out_ready: 0x11..0x44 emerge in order, then count=0, out_valid=0.
REQ-021 First-word latency.
  - Stimulus: single push of 0xA5 into an empty FIFO at edge k.
  - Required: out_valid=1 and out_data=0xA5 in cycle k+1.
REQ-022 Full with simultaneous pop.
  - Stimulus: FIFO full; in_valid=1 and out_ready=1 for one cycle.
  - Required: pop only, count 4 -> 3, and in_ready=1 on the next cycle.
REQ-023 Streaming wrap-around.
  - Stimulus: in_valid=out_ready=1 continuously for 10 pushes of 0..9.
  - Required: output sequence 0..9, count never exceeds 1, pointers wrap past 3 correctly.
REQ-024 Clear and reset mid-operation.
  - clear: with count=3, pulse clear for one cycle; required in_ready=out_valid=0 during the pulse, count=0 afterwards.
  - rst: with count=2, assert rst asynchronously; required out_valid=0 immediately and in_ready=1 after release.
